// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message scheduler: pads a 32-bit word stream to FIPS 180-4 and issues 512-bit blocks.
// Optional block counter is built when SHA256_SCHED_STATS_EN is defined.
module sha256_msg_scheduler #(
   parameter int LEN_W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  s_data,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic         s_last,
   input  logic [2:0]   s_bytes,
   output logic [511:0] blk_data,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic         blk_first,
   output logic         blk_last,
   output logic         busy,
   output logic         msg_done,
   output logic [15:0]  blk_count
);

   typedef enum logic [1:0] {FILL, PAD, LEN, ISSUE} state_t;

   state_t             state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic [15:0][31:0]  buf_q, buf_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               first_q, first_d;
   logic               last_q, last_d;
   logic               pad_pend_q, pad_pend_d;
   logic               len_pend_q, len_pend_d;
   logic               done_q, done_d;
   logic [63:0]        len64_s;

   // Keep the valid leading bytes of the final word and append the 0x80 marker.
   function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [2:0] nb);
      logic [31:0] r;
      case (nb)
         3'd0:    r = 32'h8000_0000;
         3'd1:    r = {w[31:24], 24'h80_0000};
         3'd2:    r = {w[31:16], 16'h8000};
         3'd3:    r = {w[31:8], 8'h80};
         default: r = w;
      endcase
      return r;
   endfunction

   // Zero-extend the running bit length to the 64-bit trailer field.
   always_comb begin
      len64_s = 64'd0;
      len64_s[LEN_W-1:0] = len_q;
   end

   // Next-state logic; buf word idx lives at buf[15-idx] so w0 lands in [511:480].
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      buf_d      = buf_q;
      len_d      = len_q;
      first_d    = first_q;
      last_d     = last_q;
      pad_pend_d = pad_pend_q;
      len_pend_d = len_pend_q;
      done_d     = 1'b0;
      case (state_q)
         FILL: begin
            if (s_valid) begin
               idx_d = idx_q + 4'd1;
               if (s_last) begin
                  buf_d[4'd15 - idx_q] = pad_word(s_data, s_bytes);
                  len_d = len_q + LEN_W'({s_bytes, 3'b000});
                  if (s_bytes >= 3'd4) begin
                     // A full final word at idx 15 leaves no room: pad goes in the next block.
                     if (idx_q == 4'd15) begin
                        state_d    = ISSUE;
                        pad_pend_d = 1'b1;
                     end else begin
                        state_d = PAD;
                     end
                  end else if (idx_q <= 4'd13) begin
                     state_d = LEN;
                  end else begin
                     state_d    = ISSUE;
                     len_pend_d = 1'b1;
                  end
               end else begin
                  buf_d[4'd15 - idx_q] = s_data;
                  len_d = len_q + LEN_W'(32);
                  if (idx_q == 4'd15) begin
                     state_d = ISSUE;
                  end else begin
                     state_d = FILL;
                  end
               end
            end else begin
               state_d = FILL;
            end
         end
         PAD: begin
            buf_d[4'd15 - idx_q] = 32'h8000_0000;
            idx_d = idx_q + 4'd1;
            if (idx_q <= 4'd13) begin
               state_d = LEN;
            end else begin
               state_d    = ISSUE;
               len_pend_d = 1'b1;
            end
         end
         LEN: begin
            buf_d[1] = len64_s[63:32];
            buf_d[0] = len64_s[31:0];
            last_d   = 1'b1;
            state_d  = ISSUE;
         end
         ISSUE: begin
            if (blk_ready) begin
               buf_d   = '0;
               idx_d   = 4'd0;
               first_d = 1'b0;
               if (last_q) begin
                  done_d  = 1'b1;
                  len_d   = '0;
                  first_d = 1'b1;
                  last_d  = 1'b0;
                  state_d = FILL;
               end else if (pad_pend_q) begin
                  pad_pend_d = 1'b0;
                  state_d    = PAD;
               end else if (len_pend_q) begin
                  len_pend_d = 1'b0;
                  state_d    = LEN;
               end else begin
                  state_d = FILL;
               end
            end else begin
               state_d = ISSUE;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FILL;
         idx_q      <= 4'd0;
         buf_q      <= '0;
         len_q      <= '0;
         first_q    <= 1'b1;
         last_q     <= 1'b0;
         pad_pend_q <= 1'b0;
         len_pend_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         buf_q      <= buf_d;
         len_q      <= len_d;
         first_q    <= first_d;
         last_q     <= last_d;
         pad_pend_q <= pad_pend_d;
         len_pend_q <= len_pend_d;
         done_q     <= done_d;
      end
   end

   assign s_ready   = (state_q == FILL);
   assign blk_valid = (state_q == ISSUE);
   assign blk_first = (state_q == ISSUE) && first_q;
   assign blk_last  = (state_q == ISSUE) && last_q;
   assign blk_data  = buf_q;
   assign busy      = !((state_q == FILL) && (idx_q == 4'd0));
   assign msg_done  = done_q;

`ifdef SHA256_SCHED_STATS_EN
   logic [15:0] cnt_q;

   // Completed block handshakes, wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 16'd0;
      end else if (blk_valid && blk_ready) begin
         cnt_q <= cnt_q + 16'd1;
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign blk_count = cnt_q;
`else
   assign blk_count = 16'd0;
`endif

endmodule

// File: doc/sha256_msg_scheduler.md
# sha256_msg_scheduler

Streaming front-end controller for the SHA-256 compression core. It accepts a message as 32-bit big-endian words and performs FIPS 180-4 padding and length insertion. It packs the result into 512-bit blocks and issues them to the core over a valid/ready handshake, flagging the first block (load IV) and the last block (final digest). It sits between the host/DMA word stream and `sha_256_accelerator`-class cores.

## Interface
- LEN_W, 64, width of message bit-length counter (16..64); length field is zero-extended to 64 bits
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_data  in  32  message word, first byte in [31:24]
- s_valid  in  1  s_data valid
- s_ready  out  1  word accepted when s_valid && s_ready
- s_last  in  1  final word of message
- s_bytes  in  3  valid bytes in final word, 0..4 (0 legal only with s_last); ignored when !s_last
- blk_data  out  512  block, w0 in [511:480] .. w15 in [31:0]
- blk_valid  out  1  block valid
- blk_ready  in  1  core accepts block
- blk_first  out  1  block is first of message
- blk_last  out  1  block is last of message
- busy  out  1  state != IDLE/FILL-empty (message in progress)
- msg_done  out  1  one-cycle pulse after last block handshake
- blk_count  out  16  blocks issued since reset (see Configuration)

## Operation
- States: FILL, PAD, LEN, ISSUE. Reset → FILL, idx=0, buffer zero, len=0, first=1.
- FILL: s_ready=1. Accepted word written to buf[idx] and len += 32 (or 8*s_bytes on last). Non-last word at idx 15 → ISSUE. Last word:
  - s_bytes=1..3: the valid bytes are kept, byte 0x80 is written immediately after them, and the rest is zeroed.
  - s_bytes=0: word written as 0x80000000.
  - s_bytes=4: word stored unmodified and PAD pending.
  - Next state: PAD if pending; else LEN if the pad word sits at idx ≤13; else ISSUE with len_pend set.
- PAD: writes 0x80000000 at buf[idx]. Next state: LEN if idx ≤13, else ISSUE with len_pend set.
- LEN: buf[14]=len[63:32], buf[15]=len[31:0]; sets last; next ISSUE.
- ISSUE: blk_valid=1, s_ready=0. On handshake:
  - Buffer cleared, idx=0, first cleared, blk_count++.
  - If last: msg_done pulse, len=0, first=1, return to FILL.
  - Else if pad_pend: go to PAD (idx=0).
  - Else if len_pend: go to LEN.
  - Else: go to FILL.
- Padding zeros cost no cycles: the buffer is pre-cleared on every handshake.
- len wraps mod 2^LEN_W; no error is reported.

## Timing
- Reset values: s_ready=1, blk_valid=0, blk_first=0, blk_last=0, blk_data=0, busy=0, msg_done=0, blk_count=0.
- All outputs are registered or state-decoded; there is no combinational path from blk_ready to s_ready.
- Last word (s_bytes<4, idx≤13) accepted at cycle T: LEN at T+1, blk_valid at T+2.
- s_bytes=4 at cycle T: PAD at T+1, LEN at T+2, blk_valid at T+3.
- Full non-last block: 16th word accepted at T, blk_valid at T+1.
- blk_data, blk_first and blk_last are stable while blk_valid && !blk_ready.
- After handshake at T: s_ready=1 at T+1 (FILL), or PAD/LEN runs at T+1.
- msg_done is asserted in the cycle after the final handshake.
- Async reset mid-message discards the partial block. No block is issued, and outputs take reset values immediately.

## Configuration
- SHA256_SCHED_STATS_EN defined: blk_count is a 16-bit wrapping counter of completed block handshakes.
- SHA256_SCHED_STATS_EN undefined: the counter is not built and blk_count is tied to 0.

## Test plan
- "abc" as a single word 0x61626300, s_bytes=3, s_last → one block: w0=0x61626380, w1..w14=0, w15=0x00000018, first=last=1, blk_valid at T+2.
- Empty message (s_bytes=0, s_last) → one block: w0=0x80000000, all other words 0, w15=0, first=last=1.
- 56-byte message (14 words, last s_bytes=4) → two blocks:
  - Block 1: w14=0x80000000, w15=0, first=1, last=0.
  - Block 2: w0..w14=0, w15=0x000001C0, first=0, last=1.
- 64-byte message (16 words) → two blocks:
  - Block 1: data only, first=1, last=0.
  - Block 2: w0=0x80000000, w15=0x00000200, last=1.
  - blk_count=2 with the macro defined; 0 without.
- Backpressure: hold blk_ready=0 for 10 cycles → blk_valid, data and flags are stable, s_ready=0. Raise blk_ready → one handshake, then msg_done pulse.
- Assert rst during word 7 of a message → all outputs reach reset values with no blk_valid. A following "abc" message produces the first vector exactly.
